fft16_ctrl: RTL
===============

// Module: fft16_ctrl
// PURPOSE
//  Sequencer for the 16-point radix-2 DIT FFT (4 stages x 8 butterflies). Per butterfly it
//  issues operand read addresses to the data RAM, the 3-bit twiddle index to the twiddle ROMs
//  (rom16_re/rom16_im), and the delayed write-back addresses. Sits between the top-level
//  start/done handshake and the butterfly datapath; data in RAM is bit-reversed on entry.
// PARAMETERS
//  BF_LAT  2  butterfly latency in cycles, read issue -> write-back; legal range 1..8
// PORTS
//  clk      in   1  clock; all state changes on rising edge
//  rst      in   1  synchronous, active-high reset
//  Start    in   1  start request; sampled only in IDLE
//  Busy     out  1  high in RUN and DRAIN
//  Done     out  1  one-cycle pulse when the transform completes
//  Stage    out  2  current stage s, 0..3
//  RdEn     out  1  butterfly issue strobe
//  RdAddrA  out  4  upper-leg operand address
//  RdAddrB  out  4  lower-leg operand address
//  TwAddr   out  3  twiddle ROM address, value k of W16^k
//  WrEn     out  1  write-back strobe, RdEn delayed BF_LAT cycles
//  WrAddrA  out  4  RdAddrA delayed BF_LAT cycles
//  WrAddrB  out  4  RdAddrB delayed BF_LAT cycles
// BEHAVIOUR
//  - Moore outputs, decoded from registered state/counters plus a BF_LAT-deep delay line
//  - FSM: IDLE -Start-> RUN; RUN -(b==7)-> DRAIN; DRAIN -(BF_LAT cycles)-> RUN (s+1) or DONE (s==3);
//    DONE -> IDLE, unconditionally after one cycle
//  - RUN: butterfly counter b = 0..7, one per cycle; RdEn=1
//  - address generation, with span=2^s, j=b mod span, g=b>>s:
//    RdAddrA=g*2*span+j; RdAddrB=RdAddrA+span; TwAddr=j<<(3-s), truncated to 3 bits
//  - DRAIN: RdEn=0; holds the next stage until the last write of the current stage has
//    issued (RAW hazard between stages); WrEn pulses continue from the delay line
//  - stage duration 8+BF_LAT cycles; Done at cycle 4*(8+BF_LAT)+1 after the Start edge
//    (cycle 41 for BF_LAT=2); first RdEn at cycle 1
//  - Start during RUN/DRAIN/DONE: ignored. Start held high: a new transform begins on the cycle
//    after DONE (the IDLE cycle samples it)
//  - reset, incl. mid-run: state=IDLE, counters=0, delay line cleared; every output is 0 the
//    cycle after the rst edge. Pending write-backs are discarded
//  - reset value of all outputs: 0
//  - while RdEn=0, RdAddrA/RdAddrB/TwAddr are don't-care but must hold stable
//    (frozen counters)
// CONFIGURATION
//  FFT16_INVERSE_EN defined:
//    - adds input Inverse (1 bit) and output TwConj (1 bit)
//    - Inverse is latched on the accepted Start
//    - TwConj = latched Inverse while RdEn=1, else 0; the datapath negates the rom16_im output
//      (conjugate twiddle) -> IFFT
//    - latch cleared by reset
//  FFT16_INVERSE_EN undefined: neither port exists; forward FFT only; otherwise identical timing
// TESTING
//  1. rst, then Start=1 for 1 cycle, BF_LAT=2 -> RdEn cycles 1-8, DRAIN 9-10, Stage=1 at 11,
//     Done pulse at cycle 41 only
//  2. Address check -> s0 b3: A6 B7 Tw0; s1 b3: A5 B7 Tw4; s2 b5: A9 B13 Tw2; s3 b7: A7 B15 Tw7
//  3. WrEn/WrAddrA/WrAddrB equal RdEn/RdAddrA/RdAddrB shifted by exactly BF_LAT; sweep BF_LAT
//     1, 2, 5 -> 32 WrEn pulses per run and no overlap between stages
//  4. Start re-asserted at cycle 20 -> ignored, Done still at cycle 41;
//     Start held high -> second run's first RdEn at cycle 43
//  5. rst asserted at cycle 15 -> from cycle 16: all outputs 0, state IDLE;
//     new Start gives a full normal run
//  6. FFT16_INVERSE_EN defined, Inverse=1 at Start -> TwConj=1 exactly when RdEn=1;
//     Inverse=0 -> TwConj never 1

Source files
------------

// File: rtl/fft16_ctrl.sv
// fft16_ctrl - address/control sequencer for a 16-point radix-2 DIT FFT
//
// Runs 4 stages of 8 butterflies over data that is already bit-reversed in RAM.
// Each butterfly issue produces two operand read addresses and a twiddle ROM index.
// The same addresses come back out BF_LAT cycles later as write-back addresses.
//
// Parameters
//   BF_LAT   butterfly latency, read issue -> write-back, 1..8 (default 2)
//
// Ports
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   Start    start request, sampled only while idle
//   Inverse  (FFT16_INVERSE_EN only) selects IFFT, latched on the accepted Start
//   TwConj   (FFT16_INVERSE_EN only) conjugate-twiddle flag, valid with RdEn
//   Busy     high while butterflies are issuing or draining
//   Done     one-cycle completion pulse
//   Stage    current stage 0..3
//   RdEn     butterfly issue strobe
//   RdAddrA  upper-leg operand address
//   RdAddrB  lower-leg operand address
//   TwAddr   twiddle index k of W16^k
//   WrEn     write-back strobe (RdEn delayed BF_LAT)
//   WrAddrA  RdAddrA delayed BF_LAT
//   WrAddrB  RdAddrB delayed BF_LAT
//
// Optional feature macro: FFT16_INVERSE_EN (adds Inverse/TwConj for the inverse transform)
//
// state    | meaning
// ---------+------------------------------------------------------------
// st_idle  | waiting for Start; counters cleared
// st_run   | one butterfly issued per cycle, bf_q = 0..7
// st_drain | no issue; waits BF_LAT cycles so the stage's last write lands
// st_done  | one-cycle Done pulse, then back to idle

module fft16_ctrl #(
    parameter int BF_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Start,
`ifdef FFT16_INVERSE_EN
    input  logic       Inverse,
    output logic       TwConj,
`endif
    output logic       Busy,
    output logic       Done,
    output logic [1:0] Stage,
    output logic       RdEn,
    output logic [3:0] RdAddrA,
    output logic [3:0] RdAddrB,
    output logic [2:0] TwAddr,
    output logic       WrEn,
    output logic [3:0] WrAddrA,
    output logic [3:0] WrAddrB
);

    localparam logic [1:0] st_idle  = 2'd0;
    localparam logic [1:0] st_run   = 2'd1;
    localparam logic [1:0] st_drain = 2'd2;
    localparam logic [1:0] st_done  = 2'd3;

    logic [1:0] state_q;
    logic [1:0] stage_q;
    logic [2:0] bf_q;
    logic [2:0] drain_q;

    logic [3:0] addr_a;
    logic [3:0] addr_b;
    logic [2:0] tw_idx;
    logic [3:0] span;

    logic [BF_LAT-1:0][8:0] dly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= st_idle;
            stage_q <= '0;
            bf_q    <= '0;
            drain_q <= '0;
        end else begin
            case (state_q)
                st_idle: begin
                    if (Start) begin
                        state_q <= st_run;
                        stage_q <= '0;
                        bf_q    <= '0;
                    end
                end
                st_run: begin
                    if (bf_q == 3'd7) begin
                        state_q <= st_drain;
                        drain_q <= 3'(BF_LAT - 1);
                    end else begin
                        bf_q <= bf_q + 3'd1;
                    end
                end
                st_drain: begin
                    // bf_q and stage_q stay frozen so the address outputs hold
                    if (drain_q == 3'd0) begin
                        if (stage_q == 2'd3) begin
                            state_q <= st_done;
                        end else begin
                            state_q <= st_run;
                            stage_q <= stage_q + 2'd1;
                            bf_q    <= '0;
                        end
                    end else begin
                        drain_q <= drain_q - 3'd1;
                    end
                end
                default: begin
                    state_q <= st_idle;
                    stage_q <= '0;
                    bf_q    <= '0;
                end
            endcase
        end
    end

    // Upper-leg address is g*2*span + j: the butterfly index with a zero
    // bit inserted at position s. The twiddle index is j scaled to 8 steps.
    always_comb begin
        addr_a = '0;
        tw_idx = '0;
        case (stage_q)
            2'd0: begin
                addr_a = {bf_q, 1'b0};
                tw_idx = 3'd0;
            end
            2'd1: begin
                addr_a = {bf_q[2:1], 1'b0, bf_q[0]};
                tw_idx = {bf_q[0], 2'b00};
            end
            2'd2: begin
                addr_a = {bf_q[2], 1'b0, bf_q[1:0]};
                tw_idx = {bf_q[1:0], 1'b0};
            end
            default: begin
                addr_a = {1'b0, bf_q};
                tw_idx = bf_q;
            end
        endcase
    end

    assign span   = 4'b0001 << stage_q;
    assign addr_b = addr_a | span;

    assign Busy  = (state_q == st_run) || (state_q == st_drain);
    assign Done  = (state_q == st_done);
    assign RdEn  = (state_q == st_run);
    assign Stage = stage_q;

    // Addresses are forced to 0 outside RUN/DRAIN so idle and reset read as all-zero
    assign RdAddrA = Busy ? addr_a : '0;
    assign RdAddrB = Busy ? addr_b : '0;
    assign TwAddr  = Busy ? tw_idx : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            dly_q <= '0;
        end else begin
            dly_q[0] <= {RdEn, RdAddrA, RdAddrB};
            for (int i = 1; i < BF_LAT; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign WrEn    = dly_q[BF_LAT-1][8];
    assign WrAddrA = dly_q[BF_LAT-1][7:4];
    assign WrAddrB = dly_q[BF_LAT-1][3:0];

`ifdef FFT16_INVERSE_EN
    logic inv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            inv_q <= 1'b0;
        end else if ((state_q == st_idle) && Start) begin
            inv_q <= Inverse;
        end
    end

    assign TwConj = inv_q & RdEn;
`endif

endmodule
